// File: rtl/counter_sequencer.sv
// Run/hold/done count sequencer with a configurable terminal count and one-shot
// or periodic operation; every output is taken directly from a flop.
module counter_sequencer #(
    parameter logic [3:0] DEFAULT_LIMIT = 4'd15,
    parameter logic       DEFAULT_MODE  = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    input  logic       cfg_we,
    input  logic [3:0] cfg_limit,
    input  logic       cfg_mode,
    output logic [3:0] count,
    output logic [1:0] state,
    output logic       busy,
    output logic       done,
    output logic       tc_pulse,
    output logic [7:0] periods,
    output logic       cfg_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] count_q, count_d;
    logic [3:0] limit_q, limit_d;
    logic       mode_q, mode_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       tc_q, tc_d;
    logic [7:0] periods_q, periods_d;
    logic       cfg_err_q, cfg_err_d;
    logic       active_s;

    // Next-state, configuration and status computation.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        limit_d   = limit_q;
        mode_d    = mode_q;
        tc_d      = 1'b0;
        periods_d = periods_q;
        cfg_err_d = 1'b0;
        active_s  = (state_q == ST_RUN) || (state_q == ST_HOLD);

        // Configuration is only safe to change while no run is in flight.
        if (cfg_we) begin
            if (active_s) begin
                cfg_err_d = 1'b1;
            end else begin
                limit_d = cfg_limit;
                mode_d  = cfg_mode;
            end
        end else begin
            cfg_err_d = 1'b0;
        end

        if (stop) begin
            state_d = ST_IDLE;
            count_d = 4'd0;
        end else if (pause) begin
            // Pause freezes everything, including a pending terminal count.
            if (state_q == ST_RUN) begin
                state_d = ST_HOLD;
            end else begin
                state_d = state_q;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    count_d = 4'd0;
                    if (start) begin
                        state_d   = ST_RUN;
                        periods_d = 8'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (count_q == limit_q) begin
                        tc_d      = 1'b1;
                        periods_d = (periods_q == 8'd255) ? 8'd255 : periods_q + 8'd1;
                        if (mode_q) begin
                            count_d = 4'd0;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        count_d = count_q + 4'd1;
                    end
                end
                ST_HOLD: begin
                    state_d = ST_RUN;
                end
                ST_DONE: begin
                    if (start) begin
                        state_d   = ST_RUN;
                        count_d   = 4'd0;
                        periods_d = 8'd0;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    count_d = 4'd0;
                end
            endcase
        end

        busy_d = (state_d == ST_RUN) || (state_d == ST_HOLD);
        done_d = (state_d == ST_DONE);
    end

    // State and registered outputs, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            count_q   <= 4'd0;
            limit_q   <= DEFAULT_LIMIT;
            mode_q    <= DEFAULT_MODE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            tc_q      <= 1'b0;
            periods_q <= 8'd0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            limit_q   <= limit_d;
            mode_q    <= mode_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            tc_q      <= tc_d;
            periods_q <= periods_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign count    = count_q;
    assign state    = state_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign tc_pulse = tc_q;
    assign periods  = periods_q;
    assign cfg_err  = cfg_err_q;

endmodule
